// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial values into a
// magnitude comparator and resolves the comparator's other operand bit by bit.
module sar_search_ctrl #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic {
    IDLE,
    PROBE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] settle_cnt;

  logic             one_hot;
  logic [WIDTH-1:0] kept_acc;
  logic [WIDTH-1:0] next_guess;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    one_hot    = 1'b0;
    kept_acc   = acc;
    next_guess = '0;
    one_hot    = $onehot({gt, eq, lt});
    if (lt) kept_acc = guess;
    next_guess = kept_acc | (ONE << (bit_idx - IDX_W'(1)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      bit_idx    <= '0;
      settle_cnt <= '0;
      guess      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            bit_idx    <= TOP_IDX;
            guess      <= ONE << TOP_IDX;
            settle_cnt <= SETTLE_LD;
            busy       <= 1'b1;
            err        <= 1'b0;
            state      <= PROBE;
          end
        end
        PROBE: begin
          // Comparator inputs only matter once the settle window has elapsed.
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else if (!one_hot) begin
            err    <= 1'b1;
            result <= acc;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (eq) begin
            result <= guess;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            acc <= kept_acc;
            if (bit_idx != '0) begin
              bit_idx    <= bit_idx - IDX_W'(1);
              guess      <= next_guess;
              settle_cnt <= SETTLE_LD;
            end else begin
              result <= kept_acc;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: a combinational-comparator instance (settle 0,
// with fault injection) and a twice-registered-comparator instance (settle 2).
module tb_sar_search_ctrl;

  typedef struct {
    int probes[4];
    int n;
    int result;
    bit err;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start2;
  logic       gt0, eq0, lt0, gt2, eq2, lt2;
  logic [3:0] guess0, result0, guess2, result2;
  logic       busy0, done0, err0, busy2, done2, err2;
  logic [3:0] target0 = '0, target2 = '0;
  logic       fault_en = 1'b0;
  logic [3:0] fault_g  = '0;
  logic [2:0] c1 = '0, c2 = '0;

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     sel      = 1'b0;
  bit     mon_on   = 1'b0;
  int     mon_n    = 0;
  int     mon_st   = 0;
  model_t mm;

  always #5 clk = ~clk;

  sar_search_ctrl #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .gt(gt0), .eq(eq0), .lt(lt0),
    .guess(guess0), .busy(busy0), .done(done0), .result(result0), .err(err0)
  );

  sar_search_ctrl #(.WIDTH(4), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .gt(gt2), .eq(eq2), .lt(lt2),
    .guess(guess2), .busy(busy2), .done(done2), .result(result2), .err(err2)
  );

  // Combinational comparator, optionally reporting gt and lt together on one guess.
  always_comb begin
    gt0 = guess0 > target0;
    eq0 = guess0 == target0;
    lt0 = guess0 < target0;
    if (fault_en && guess0 == fault_g) begin
      gt0 = 1'b1;
      eq0 = 1'b0;
      lt0 = 1'b1;
    end
  end

  // Comparator with two register stages between guess and result.
  always @(posedge clk) begin
    c1 <= {guess2 > target2, guess2 == target2, guess2 < target2};
    c2 <= c1;
  end
  assign {gt2, eq2, lt2} = c2;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Binary search over the value range, one trial bit per probe.
  function automatic model_t run_model(input int tgt, input bit f_en, input int f_g);
    model_t m;
    int acc;
    int g;
    m.n = 0;
    m.result = 0;
    m.err = 1'b0;
    for (int i = 0; i < 4; i++) m.probes[i] = 0;
    acc = 0;
    for (int b = 3; b >= 0; b--) begin
      g = acc + (1 << b);
      m.probes[m.n] = g;
      m.n++;
      if (f_en && g == f_g) begin
        m.err = 1'b1;
        m.result = acc;
        return m;
      end
      if (g == tgt) begin
        m.result = g;
        return m;
      end
      if (g < tgt) acc = g;
    end
    m.result = acc;
    return m;
  endfunction

  // Per-cycle compare: mon_n counts edges since the start-accepting edge.
  always @(negedge clk) begin
    if (mon_on) begin
      int lat;
      int idx;
      lat = mm.n * (mon_st + 1);
      idx = ((mon_n < lat) ? mon_n : lat - 1) / (mon_st + 1);
      check("guess", int'(sel ? guess2 : guess0), mm.probes[idx]);
      check("busy",  int'(sel ? busy2 : busy0),   int'(mon_n < lat));
      check("done",  int'(sel ? done2 : done0),   int'(mon_n == lat));
      if (mon_n >= lat) begin
        check("result", int'(sel ? result2 : result0), mm.result);
        check("err",    int'(sel ? err2 : err0),       int'(mm.err));
      end else begin
        check("err_busy", int'(sel ? err2 : err0), 0);
      end
    end
  end

  task automatic search(input bit s, input int tgt, input bit hold, input bit chained);
    model_t nm;
    int     lat;
    nm = run_model(tgt, fault_en && !s, int'(fault_g));
    if (!chained) begin
      @(negedge clk);
      sel = s;
      if (s) begin target2 = 4'(tgt); start2 = 1'b1; end
      else   begin target0 = 4'(tgt); start0 = 1'b1; end
    end
    @(posedge clk);
    mm     = nm;
    mon_st = s ? 2 : 0;
    mon_n  = 0;
    mon_on = 1'b1;
    @(negedge clk);
    if (!hold) begin
      start0 = 1'b0;
      start2 = 1'b0;
    end
    lat = nm.n * (mon_st + 1);
    while (mon_n < lat) begin
      @(posedge clk);
      mon_n++;
    end
    if (!hold) begin
      @(posedge clk);
      mon_n++;
      @(posedge clk);
      mon_on = 1'b0;
    end
  endtask

  initial begin
    model_t m;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_guess0",  int'(guess0),  0);
    check("rst_busy0",   int'(busy0),   0);
    check("rst_done0",   int'(done0),   0);
    check("rst_result0", int'(result0), 0);
    check("rst_err0",    int'(err0),    0);
    check("rst_guess2",  int'(guess2),  0);
    rst_n = 1'b1;

    m = run_model(10, 1'b0, 0);
    check("model10_p1", m.probes[1], 12);
    check("model10_p2", m.probes[2], 10);
    check("model10_n",  m.n,         3);
    m = run_model(0, 1'b0, 0);
    check("model0_last", m.probes[3], 1);
    check("model0_res",  m.result,    0);
    m = run_model(15, 1'b0, 0);
    check("model15_p2", m.probes[2], 14);
    check("model15_n",  m.n,         4);
    m = run_model(10, 1'b1, 12);
    check("modelf_n",   m.n,      2);
    check("modelf_res", m.result, 8);
    check("modelf_err", int'(m.err), 1);

    search(1'b0, 10, 1'b0, 1'b0);
    search(1'b0, 0,  1'b0, 1'b0);
    search(1'b0, 15, 1'b0, 1'b0);
    search(1'b0, 6,  1'b0, 1'b0);

    fault_g  = 4'd12;
    fault_en = 1'b1;
    search(1'b0, 10, 1'b0, 1'b0);
    fault_en = 1'b0;
    search(1'b0, 10, 1'b0, 1'b0);

    search(1'b1, 11, 1'b0, 1'b0);
    search(1'b1, 0,  1'b0, 1'b0);

    // start held high: second search begins right after the done cycle.
    search(1'b0, 5, 1'b1, 1'b0);
    search(1'b0, 5, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a search.
    @(negedge clk);
    target0 = 4'd10;
    start0  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_guess",  int'(guess0),  0);
    check("mid_rst_busy",   int'(busy0),   0);
    check("mid_rst_done",   int'(done0),   0);
    check("mid_rst_result", int'(result0), 0);
    check("mid_rst_err",    int'(err0),    0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_busy",  int'(busy0),  0);
      check("post_rst_done",  int'(done0),  0);
      check("post_rst_guess", int'(guess0), 0);
    end
    search(1'b0, 7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Successive-approximation search controller that sits on the opposite side of the `four_bit_comparator`. It drives the comparator's `a` input with trial values and reads back `gt`/`eq`/`lt`, while an external target value drives `b`. From those results it resolves the target value in at most WIDTH probes. It turns the combinational comparator into a sequential value-finder, for use in threshold search and self-checking benches.

## Interface
- `WIDTH`, 4: bit width of the guess, the target and the result.
- `SETTLE_CYCLES`, 0: extra wait cycles between driving a guess and sampling the comparator. Use 0 for a combinational comparator; use ≥1 for a registered or pipelined one.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new search; sampled only in IDLE.
- `gt`  in  1  comparator result: guess > target.
- `eq`  in  1  comparator result: guess == target.
- `lt`  in  1  comparator result: guess < target.
- `guess`  out  WIDTH  trial value; connects to comparator `a`.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle pulse when `result`/`err` become valid.
- `result`  out  WIDTH  resolved target value; held until the next accepted `start`.
- `err`  out  1  comparator returned a non-one-hot result during the last search.

## Operation
- States:
  - IDLE: waits for `start`.
  - PROBE: drives `guess` and counts down `settle_cnt`.
  - SAMPLE: decision point, entered when `settle_cnt == 0`. Implementations may merge it into PROBE.
- Internal registers:
  - `acc[WIDTH-1:0]`: accumulated result.
  - `bit_idx`: ceil(log2(WIDTH)) bits.
  - `settle_cnt`: wide enough to hold SETTLE_CYCLES.
- In IDLE with `start` = 1:
  - `acc` ← 0, `bit_idx` ← WIDTH-1, `guess` ← 1 << (WIDTH-1), `settle_cnt` ← SETTLE_CYCLES.
  - `busy` ← 1, `err` ← 0; go to PROBE.
- `guess` always equals `acc | (1 << bit_idx)`. It is registered and stable for the whole probe.
- Decision rules when sampling:
  - Exactly one of gt/eq/lt is high is required; otherwise `err` ← 1, `result` ← `acc`, finish.
  - `eq`: `result` ← `guess`; finish early.
  - `lt`: `acc` ← `guess` (keep the trial bit).
  - `gt`: `acc` unchanged (drop the trial bit).
  - Not finished and `bit_idx` > 0: `bit_idx` ← `bit_idx` - 1, reload `settle_cnt`, drive the next guess.
  - `bit_idx` == 0 and not `eq`: `result` ← updated `acc`; finish.
- Finish actions:
  - `busy` ← 0 and `done` ← 1 for exactly one cycle; return to IDLE.
  - `guess` holds its last value.
- Target 0 never produces `eq`, because every probe is nonzero. After WIDTH `gt` results it resolves to `result` = 0 with `err` = 0.
- `start` while `busy`: ignored. `start` in the same cycle as `done`: accepted, because the state is already IDLE.
- Reset values (also applied on mid-search reset, immediately and asynchronously):
  - `guess`, `result`, `acc` = 0.
  - `busy`, `done`, `err` = 0.
  - state = IDLE.
  - No partial result is retained.

## Timing
- `start` is sampled at edge k. Then `guess` = first probe and `busy` = 1 after edge k.
- Probe n (1-based) is sampled at edge k + n·(SETTLE_CYCLES+1).
- `done`, `result` and `err` update at the final sampling edge. `done` is high for one cycle, and `busy` falls at that same edge.
- Latency from `start` edge to `done`:
  - worst case WIDTH·(SETTLE_CYCLES+1) cycles;
  - best case (`eq` on the first probe) SETTLE_CYCLES+1 cycles.
- Comparator inputs are ignored except at sampling edges; glitches during settle have no effect.

## Test plan
- WIDTH=4, SETTLE=0, target=10:
  - probes 8 (lt), 12 (gt), 10 (eq).
  - `done` at edge k+3, `result` = 10, `err` = 0.
- target=0:
  - probes 8, 4, 2, 1, all gt.
  - `done` at k+4, `result` = 0, `err` = 0.
- target=15:
  - probes 8, 12, 14 (lt), 15 (eq).
  - `done` at k+4, `result` = 15.
- SETTLE=2, target=11, with a comparator registered twice:
  - probes 8, 12, 10, 11; each guess is held 3 cycles.
  - `done` at k+12, `result` = 11.
- Faulty comparator forcing gt=lt=1 on probe 2, target=10:
  - `done` at k+2, `err` = 1, `result` = 8.
  - A following clean `start` clears `err`.
- Back-to-back and reset:
  - `start` held high through a search: a new search starts the cycle `done` pulses, and is ignored while busy.
  - `rst_n` low mid-search: all outputs are 0 immediately, no `done`, and the block is IDLE after release.
